// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF digit buffer: marker default, gap FSM
// states and the receiver's digit-code encoding.
package dtmf_pkg;

  // End-of-string marker appended after the inter-digit silence.
  localparam logic [7:0] EOS_CODE_DEFAULT = 8'hFF;

  // Gap FSM: IDLE has no open string, COLLECT times the silence.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } gap_state_e;

  // Digit codes as presented on the receiver's tdigit bus.
  typedef enum logic [7:0] {
    DTMF_0    = 8'h00,
    DTMF_1    = 8'h01,
    DTMF_2    = 8'h02,
    DTMF_3    = 8'h03,
    DTMF_4    = 8'h04,
    DTMF_5    = 8'h05,
    DTMF_6    = 8'h06,
    DTMF_7    = 8'h07,
    DTMF_8    = 8'h08,
    DTMF_9    = 8'h09,
    DTMF_STAR = 8'h0A,
    DTMF_HASH = 8'h0B,
    DTMF_A    = 8'h0C,
    DTMF_B    = 8'h0D,
    DTMF_C    = 8'h0E,
    DTMF_D    = 8'h0F
  } dtmf_code_e;

  // True when a byte is one of the sixteen receiver digit codes.
  function automatic logic is_dtmf_code(input logic [7:0] code);
    return (code <= 8'h0F);
  endfunction

endpackage

// File: rtl/dtmf_sync2.sv
// Generic two-flop synchroniser for signals arriving from another clock
// domain. Output is valid two clk edges after the input settles.
module dtmf_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking so both stages sample pre-edge values and form a real two-stage chain.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dtmf_digit_buffer.sv
// DTMF digit buffer: resynchronises the receiver's digit strobe, queues each
// digit in a first-word-fall-through FIFO and appends an end-of-string
// marker after a configurable silence. The host drains with rd_en.
module dtmf_digit_buffer
  import dtmf_pkg::*;
#(
  parameter int unsigned   DEPTH      = 8,
  parameter int unsigned   AW         = 3,
  parameter int unsigned   TW         = 16,
  parameter logic [TW-1:0] GAP_CYCLES = TW'(4000),
  parameter logic [7:0]    EOS_CODE   = EOS_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tdigit,
  input  logic        tdigit_flag,
  input  logic        rd_en,
  input  logic        clr_ovf,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        eos
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] GAP_LAST   = GAP_CYCLES - 1'b1;

  // --------------------------------------------------------------------------
  // Flag input path: synchronise, then detect the rising edge.
  // --------------------------------------------------------------------------
  logic flag_sync;
  logic flag_prev_q;
  logic digit_rise;

  dtmf_sync2 #(
    .W (1)
  ) u_flag_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (tdigit_flag),
    .q_o   (flag_sync)
  );

  // Remember the last synchronised flag level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_prev_q <= 1'b0;
    end else begin
      flag_prev_q <= flag_sync;
    end
  end

  // tdigit has been stable for two cycles by the time the edge is seen, so
  // it is sampled directly without its own synchroniser.
  assign digit_rise = flag_sync & ~flag_prev_q;

  // --------------------------------------------------------------------------
  // Gap timer FSM.
  // --------------------------------------------------------------------------
  gap_state_e  state_q;
  logic [TW-1:0] timer_q;
  logic        eos_q;
  logic        marker_fire;

  // A digit arriving on the expiry cycle wins: it restarts the timer instead.
  assign marker_fire = (state_q == COLLECT) && !digit_rise && (timer_q == GAP_LAST);

  // Opens a string on a digit; closes it with a marker after GAP_CYCLES of silence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      eos_q   <= 1'b0;
    end else begin
      eos_q <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (digit_rise) begin
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (digit_rise) begin
            timer_q <= '0;
          end else if (timer_q == GAP_LAST) begin
            // eos pulses even if the marker itself is dropped at full.
            timer_q <= '0;
            state_q <= IDLE;
            eos_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control.
  // --------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          ovf_q,    ovf_d;

  logic       fifo_empty;
  logic       fifo_full;
  logic       push_req;
  logic [7:0] push_data;
  logic       pop_ok;
  logic       push_ok;
  logic       push_drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign push_req   = digit_rise | marker_fire;
  assign push_data  = digit_rise ? tdigit : EOS_CODE;

  // A pop on empty is ignored; a pop at full frees the slot for a same-cycle push.
  assign pop_ok    = rd_en && !fifo_empty;
  assign push_ok   = push_req && (!fifo_full || pop_ok);
  assign push_drop = push_req && !push_ok;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    // NOTE: every next-state defaults to its current value first, so no branch can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A set in the same cycle as a clear keeps the flag high.
    if (push_drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Pointer, occupancy and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head entry falls through combinationally.
  // --------------------------------------------------------------------------
  assign rd_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rd_valid = !fifo_empty;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign eos      = eos_q;

endmodule

// File: tb/tb_dtmf_digit_buffer.sv
// Bench for dtmf_digit_buffer: a queue-based reference model driven by the
// scheduled digit write edges, with a separate monitor comparing the DUT.
module tb_dtmf_digit_buffer;

  localparam int          DEPTH = 8;
  localparam int          AW    = 3;
  localparam int          TW    = 16;
  localparam int          GAP   = 10;
  localparam logic [7:0]  EOS   = 8'hFF;

  logic        clk;
  logic        reset;
  logic [7:0]  tdigit;
  logic        tdigit_flag;
  logic        rd_en;
  logic        clr_ovf;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [AW:0] count;
  logic        overflow;
  logic        eos;

  dtmf_digit_buffer #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .TW         (TW),
    .GAP_CYCLES (16'd10),
    .EOS_CODE   (EOS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tdigit      (tdigit),
    .tdigit_flag (tdigit_flag),
    .rd_en       (rd_en),
    .clr_ovf     (clr_ovf),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .count       (count),
    .overflow    (overflow),
    .eos         (eos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model state.
  // ---------------------------------------------------------------------------
  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } due_t;

  due_t        due_q[$];      // digits and the clk edge at which they must be written
  logic [7:0]  exp_q[$];      // expected FIFO contents, head first
  int unsigned cyc      = 0;  // posedges seen outside reset
  int unsigned last_wr  = 0;
  bit          str_open = 0;
  bit          exp_eos  = 0;
  bit          exp_ovf  = 0;
  bit          m_push;
  logic [7:0]  m_val;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: at every edge, a scheduled digit is written; otherwise the marker
  // is written GAP edges after the last digit of an open string.
  initial begin : model
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        due_q.delete();
        str_open = 0;
        exp_eos  = 0;
        exp_ovf  = 0;
      end else begin
        cyc++;
        m_push  = 0;
        m_val   = 8'h00;
        exp_eos = 0;
        if (due_q.size() != 0 && due_q[0].cyc == cyc) begin
          m_push   = 1;
          m_val    = due_q[0].data;
          void'(due_q.pop_front());
          str_open = 1;
          last_wr  = cyc;
        end else if (str_open && cyc == last_wr + GAP) begin
          m_push   = 1;
          m_val    = EOS;
          str_open = 0;
          exp_eos  = 1;
        end
        // The monitor has already removed this edge's pop from exp_q.
        if (m_push && exp_q.size() >= DEPTH) begin
          exp_ovf = 1;
        end else begin
          if (m_push) exp_q.push_back(m_val);
          if (clr_ovf) exp_ovf = 0;
        end
      end
    end
  end

  // Monitor: mid-cycle, compare outputs with the model and retire reads.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        check("count",    32'(count),    32'(exp_q.size()));
        check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("eos",      32'(eos),      32'(exp_eos));
        if (exp_q.size() != 0) begin
          check("rd_data", 32'(rd_data), 32'(exp_q[0]));
          if (rd_en) void'(exp_q.pop_front());
        end else begin
          check("rd_data_empty", 32'(rd_data), 32'h0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Each call starts just after a negedge.
  // ---------------------------------------------------------------------------
  task automatic step(input bit rd, input bit clr);
    rd_en   = rd;
    clr_ovf = clr;
    @(negedge clk);
  endtask

  // rd_mode: 0 no reads, 1 read on the digit's write edge, 2 random reads.
  task automatic send_digit(input logic [7:0] d, input int hi, input int lo,
                            input int rd_mode, input bit clr_at_write);
    due_t e;
    bit   rd;
    bit   clr;
    tdigit      = d;
    tdigit_flag = 1'b1;
    e.cyc  = cyc + 3;
    e.data = d;
    due_q.push_back(e);
    for (int i = 0; i < hi; i++) begin
      rd  = (rd_mode == 1) ? (i == 2) : (rd_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      clr = (rd_mode == 2) ? ($urandom_range(0, 15) == 0) : (clr_at_write && i == 2);
      step(rd, clr);
    end
    tdigit_flag = 1'b0;
    for (int i = 0; i < lo; i++) begin
      rd  = (rd_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      clr = (rd_mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
      step(rd, clr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("drain_empty", 32'(count), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence.
  // ---------------------------------------------------------------------------
  int unsigned w;

  initial begin : stim
    reset       = 1'b1;
    tdigit      = 8'h00;
    tdigit_flag = 1'b0;
    rd_en       = 1'b0;
    clr_ovf     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_data",  32'(rd_data),  32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_count",    32'(count),    32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_eos",      32'(eos),      32'h0);
    reset = 1'b0;
    idle(2);

    // Basic capture and drain: 05, 0B, then the marker.
    send_digit(8'h05, 4, 2, 0, 1'b0);
    send_digit(8'h0B, 4, 2, 0, 1'b0);
    idle(GAP + 2);
    check("basic_count", 32'(count), 32'd3);
    drain();

    // Gap restart: digits 9 cycles apart keep the string open.
    for (int i = 0; i < 3; i++) send_digit(8'($urandom_range(0, 15)), 4, 5, 0, 1'b0);
    idle(GAP + 2);
    check("gap_count", 32'(count), 32'd4);
    drain();

    // Empty reads leave the pointers alone.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("empty_rd_count", 32'(count), 32'h0);

    // Collision: second digit lands on the first digit's expiry edge.
    w = cyc + 3;
    send_digit(8'h03, 4, 2, 0, 1'b0);
    for (int i = 0; i < 20 && cyc < w + GAP - 3; i++) step(1'b0, 1'b0);
    send_digit(8'h0C, 4, 2, 0, 1'b0);
    idle(GAP + 2);
    check("collide_count", 32'(count), 32'd3);
    drain();

    // Overflow: nine digits, no reads.
    for (int i = 0; i < 9; i++) send_digit(8'($urandom_range(0, 15)), 3, 3, 0, 1'b0);
    check("ovf_count", 32'(count),    32'd8);
    check("ovf_set",   32'(overflow), 32'h1);
    idle(GAP);
    step(1'b0, 1'b1);
    check("ovf_clear", 32'(overflow), 32'h0);
    send_digit(8'h07, 3, 3, 0, 1'b1);
    check("ovf_set_beats_clr", 32'(overflow), 32'h1);
    idle(GAP);
    step(1'b0, 1'b1);
    // Full with a same-cycle pop: the push is accepted.
    send_digit(8'h0D, 3, 3, 1, 1'b0);
    check("full_pop_ovf",   32'(overflow), 32'h0);
    check("full_pop_count", 32'(count),    32'd8);
    idle(GAP + 2);
    step(1'b0, 1'b1);
    drain();

    // Reset mid-string with three entries queued.
    for (int i = 0; i < 3; i++) send_digit(8'($urandom_range(0, 15)), 3, 3, 0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rd_data",  32'(rd_data),  32'h0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
    check("mid_rst_count",    32'(count),    32'h0);
    check("mid_rst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(GAP + 5);

    // Randomised traffic: digits, gaps and host reads/clears.
    for (int i = 0; i < 40; i++) begin
      send_digit(8'($urandom_range(0, 15)), $urandom_range(3, 5), $urandom_range(2, 14), 2, 1'b0);
    end
    idle(GAP + 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
